vc_route_lock_unit: RTL and testbench
=====================================

// Module: vc_route_lock_unit
// PURPOSE
//  Per-input-port route-lock stage for the wormhole router, with NUM_VC virtual channels.
//  A header flit (VC flit count == 0) latches its direction field into that VC's route
//  register. Body flits on the same VC inherit that latched route until the tail flit.
//  Output is one registered pipeline stage with valid/ready backpressure toward the switch allocator.
// PARAMETERS
//  DIR_W    6  direction field width; MSB set = invalid/no-route marker
//  NUM_VC   4  number of virtual channels (>=1)
//  VC_W     2  vc index width, $clog2(NUM_VC), min 1
//  PKT_LEN  4  flits per packet incl. header (2..2**CNT_W)
//  CNT_W    3  per-VC flit counter width
// PORTS
//  clk_i         in   1        clock, rising edge
//  rst_i         in   1        asynchronous reset, active-high
//  valid_i       in   1        input flit present
//  ready_o       out  1        unit accepts flit this cycle
//  vc_i          in   VC_W     VC of input flit
//  dir_i         in   DIR_W    direction field (meaningful on header only)
//  valid_o       out  1        output flit valid
//  ready_i       in   1        downstream accepts output flit
//  vc_o          out  VC_W     VC of output flit
//  dir_o         out  DIR_W    resolved route for output flit
//  is_body_o     out  1        output flit is non-header
//  is_tail_o     out  1        output flit is last of packet
//  vc_busy_o     out  NUM_VC   bit v = VC v has a locked route (packet in flight)
//  err_o         out  1        1-cycle pulse: header with invalid route dropped
// BEHAVIOUR
//  Reset (async): valid_o=0, vc_o=0, dir_o=0, is_body_o=0, is_tail_o=0, err_o=0.
//   Also on reset: all counters=0, route regs=0, vc_busy_o=0. Applies mid-packet; partial packets are discarded.
//  Handshake: ready_o = !valid_o | ready_i (combinational). Accept = valid_i & ready_o.
//   Output holds stable while valid_o & !ready_i.
//  Latency: 1 cycle from accept to valid_o.
//  Per-VC state: IDLE (cnt==0, busy=0) / LOCKED (busy=1).
//  Accept in IDLE, dir_i[DIR_W-1]==0:
//   route[vc] <= dir_i; cnt <= 1; busy <= 1.
//   Output: dir_o=dir_i, is_body_o=0, is_tail_o=0.
//  Accept in IDLE, dir_i[DIR_W-1]==1:
//   Flit dropped; no output; cnt and route unchanged.
//   err_o=1 for the next cycle only.
//  Accept in LOCKED: dir_o=route[vc] (dir_i ignored); is_body_o=1; cnt <= cnt+1.
//  Tail condition: cnt == PKT_LEN-1.
//   On tail: is_tail_o=1, cnt <= 0, busy <= 0. The VC returns to IDLE the following cycle.
//  Counter never wraps past PKT_LEN-1. CNT_W must satisfy 2**CNT_W >= PKT_LEN.
//  VCs are independent. Flits of different VCs may interleave cycle by cycle.
//  Only the addressed VC updates on accept.
//  Header immediately after tail on same VC is legal. Back-to-back packets on one VC need no bubble.
//  vc_i >= NUM_VC: flit dropped, err_o pulses, no state change.
//  No accept (valid_i=0 or stalled): no state change; err_o=0.
// TESTING
//  Single packet, PKT_LEN=4, VC0, dir=6'h05:
//   Out dirs 05,05,05,05; is_body 0,1,1,1; is_tail 0,0,0,1.
//   vc_busy_o[0] high from cycle after header until cycle after tail.
//  Body flits with dir_i=6'h1F after header dir=6'h02: all body outputs dir_o=6'h02.
//  Interleave VC0 dir=01 and VC1 dir=03 alternating:
//   Each output carries its own VC route. Tails are flagged per VC independently.
//  Invalid header dir=6'h20 on idle VC2: no valid_o, err_o pulses 1 cycle.
//   Next header dir=6'h04 on VC2 passes as header.
//  Backpressure: hold ready_i=0 for 3 cycles mid-packet.
//   ready_o=0, output stable, no flit lost or duplicated. Counts resume correctly.
//  Assert rst_i after 2 of 4 flits on VC0: all outputs/busy 0 immediately.
//   Next flit on VC0 is treated as a header.

Source files
------------

// File: rtl/vc_route_lock_unit.sv
`default_nettype none
// ============================================================================
// Module      : vc_route_lock_unit
// Description : Per-input-port route lock for a wormhole router. Headers latch
//               a route per virtual channel; body flits inherit it until tail.
// Revision    : 1.0 - initial release
// ============================================================================
module vc_route_lock_unit #(
    parameter int DIR_W   = 6,
    parameter int NUM_VC  = 4,
    parameter int VC_W    = 2,
    parameter int PKT_LEN = 4,
    parameter int CNT_W   = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [VC_W-1:0]   vc_i,
    input  logic [DIR_W-1:0]  dir_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [VC_W-1:0]   vc_o,
    output logic [DIR_W-1:0]  dir_o,
    output logic              is_body_o,
    output logic              is_tail_o,
    output logic [NUM_VC-1:0] vc_busy_o,
    output logic              err_o
);

    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(PKT_LEN - 1);

    logic [CNT_W-1:0]  r_cnt   [NUM_VC];
    logic [DIR_W-1:0]  r_route [NUM_VC];
    logic [NUM_VC-1:0] r_busy;

    logic              r_valid;
    logic [VC_W-1:0]   r_vc;
    logic [DIR_W-1:0]  r_dir;
    logic              r_body;
    logic              r_tail;
    logic              r_err;

    logic              w_ready;
    logic              w_accept;
    logic              w_vc_ok;
    logic              w_sel_busy;
    logic [CNT_W-1:0]  w_sel_cnt;
    logic [DIR_W-1:0]  w_sel_route;
    logic [NUM_VC-1:0] w_hit;
    logic              w_emit;
    logic              w_drop;

    assign w_ready  = !r_valid || ready_i;
    assign w_accept = valid_i && w_ready;

    // Out-of-range VC indices match no entry, leaving w_vc_ok low.
    always_comb begin
        w_vc_ok     = 1'b0;
        w_sel_busy  = 1'b0;
        w_sel_cnt   = '0;
        w_sel_route = '0;
        w_hit       = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (vc_i == VC_W'(v)) begin
                w_vc_ok     = 1'b1;
                w_sel_busy  = r_busy[v];
                w_sel_cnt   = r_cnt[v];
                w_sel_route = r_route[v];
                w_hit[v]    = w_accept;
            end
        end
    end

    assign w_emit = w_accept && w_vc_ok && (w_sel_busy || !dir_i[DIR_W-1]);
    assign w_drop = w_accept && (!w_vc_ok || (!w_sel_busy && dir_i[DIR_W-1]));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_busy <= '0;
            for (int v = 0; v < NUM_VC; v++) begin
                r_cnt[v]   <= '0;
                r_route[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (w_hit[v]) begin
                    if (r_busy[v]) begin
                        if (r_cnt[v] == c_last_cnt) begin
                            r_cnt[v]  <= '0;
                            r_busy[v] <= 1'b0;
                        end else begin
                            r_cnt[v] <= r_cnt[v] + CNT_W'(1);
                        end
                    end else if (!dir_i[DIR_W-1]) begin
                        r_route[v] <= dir_i;
                        r_cnt[v]   <= CNT_W'(1);
                        r_busy[v]  <= 1'b1;
                    end
                end
            end
        end
    end

    // Payload fields only reload on an emitted flit so they stay put under stall.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_vc    <= '0;
            r_dir   <= '0;
            r_body  <= 1'b0;
            r_tail  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_drop;
            if (w_ready) begin
                r_valid <= w_emit;
                if (w_emit) begin
                    r_vc   <= vc_i;
                    r_dir  <= w_sel_busy ? w_sel_route : dir_i;
                    r_body <= w_sel_busy;
                    r_tail <= w_sel_busy && (w_sel_cnt == c_last_cnt);
                end
            end
        end
    end

    assign ready_o   = w_ready;
    assign valid_o   = r_valid;
    assign vc_o      = r_vc;
    assign dir_o     = r_dir;
    assign is_body_o = r_body;
    assign is_tail_o = r_tail;
    assign err_o     = r_err;
    assign vc_busy_o = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_vc_route_lock_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_vc_route_lock_unit
// Description : Self-checking bench for vc_route_lock_unit with packet-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vc_route_lock_unit;

    localparam int PKT_LEN = 4;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       valid_i;
    logic       ready_o;
    logic [1:0] vc_i;
    logic [5:0] dir_i;
    logic       valid_o;
    logic       ready_i;
    logic [1:0] vc_o;
    logic [5:0] dir_o;
    logic       is_body_o;
    logic       is_tail_o;
    logic [3:0] vc_busy_o;
    logic       err_o;

    vc_route_lock_unit #(
        .DIR_W(6), .NUM_VC(4), .VC_W(2), .PKT_LEN(PKT_LEN), .CNT_W(3)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .vc_i(vc_i), .dir_i(dir_i), .valid_o(valid_o), .ready_i(ready_i),
        .vc_o(vc_o), .dir_o(dir_o), .is_body_o(is_body_o), .is_tail_o(is_tail_o),
        .vc_busy_o(vc_busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: flits seen so far in the current packet of each VC.
    int         m_pos   [4];
    logic [5:0] m_route [4];
    logic       m_valid, m_body, m_tail, m_err;
    logic [1:0] m_vc;
    logic [5:0] m_dir;
    logic [3:0] exp_busy;
    bit         mon_en;
    int         err_cnt;

    logic [1:0] log_vc   [$];
    logic [5:0] log_dir  [$];
    logic       log_body [$];
    logic       log_tail [$];

    task automatic model_reset();
        for (int v = 0; v < 4; v++) begin
            m_pos[v]   = 0;
            m_route[v] = '0;
        end
        m_valid = 0; m_body = 0; m_tail = 0; m_err = 0; m_vc = '0; m_dir = '0;
    endtask

    task automatic log_clear();
        log_vc.delete(); log_dir.delete(); log_body.delete(); log_tail.delete();
        err_cnt = 0;
    endtask

    task automatic cyc(input bit v, input int vc, input int d, input bit rdy);
        valid_i = v;
        vc_i    = vc[1:0];
        dir_i   = d[5:0];
        ready_i = rdy;
        @(posedge clk);
        #2;
    endtask

    // Mid-cycle monitor: compare against model, then advance model by one edge.
    always @(negedge clk) begin
        if (mon_en && !rst_i) begin
            for (int v = 0; v < 4; v++) exp_busy[v] = (m_pos[v] != 0);
            checks++;
            if (ready_o !== (!m_valid || ready_i)) begin
                errors++;
                $display("FAIL ready_o got %b expected %b", ready_o, (!m_valid || ready_i));
            end
            checks++;
            if (valid_o !== m_valid) begin
                errors++;
                $display("FAIL valid_o got %b expected %b", valid_o, m_valid);
            end
            checks++;
            if (err_o !== m_err) begin
                errors++;
                $display("FAIL err_o got %b expected %b", err_o, m_err);
            end
            checks++;
            if (vc_busy_o !== exp_busy) begin
                errors++;
                $display("FAIL vc_busy_o got %b expected %b", vc_busy_o, exp_busy);
            end
            if (m_valid) begin
                checks++;
                if ({vc_o, dir_o, is_body_o, is_tail_o} !== {m_vc, m_dir, m_body, m_tail}) begin
                    errors++;
                    $display("FAIL out_flit got vc=%0d dir=%h body=%b tail=%b expected vc=%0d dir=%h body=%b tail=%b",
                             vc_o, dir_o, is_body_o, is_tail_o, m_vc, m_dir, m_body, m_tail);
                end
            end
            if (valid_o && ready_i) begin
                log_vc.push_back(vc_o); log_dir.push_back(dir_o);
                log_body.push_back(is_body_o); log_tail.push_back(is_tail_o);
            end
            if (err_o) err_cnt++;

            m_err = 0;
            if (!m_valid || ready_i) begin
                m_valid = 0;
                if (valid_i) begin
                    if (m_pos[vc_i] == 0) begin
                        if (dir_i[5]) m_err = 1;
                        else begin
                            m_route[vc_i] = dir_i;
                            m_pos[vc_i]   = 1;
                            m_valid = 1; m_vc = vc_i; m_dir = dir_i; m_body = 0; m_tail = 0;
                        end
                    end else begin
                        m_valid = 1; m_vc = vc_i; m_dir = m_route[vc_i]; m_body = 1;
                        m_tail  = (m_pos[vc_i] + 1 == PKT_LEN);
                        m_pos[vc_i] = m_tail ? 0 : m_pos[vc_i] + 1;
                    end
                end
            end
        end
    end

    task automatic test_reset();
        @(posedge clk);
        #2;
        checks++;
        if ({valid_o, vc_o, dir_o, is_body_o, is_tail_o, err_o, vc_busy_o} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b vc=%0d dir=%h b=%b t=%b e=%b busy=%b expected all 0",
                     valid_o, vc_o, dir_o, is_body_o, is_tail_o, err_o, vc_busy_o);
        end
        rst_i  = 0;
        mon_en = 1;
        cyc(0, 0, 0, 1);
    endtask

    task automatic test_single_packet();
        log_clear();
        for (int i = 0; i < 4; i++) cyc(1, 0, 6'h05, 1);
        cyc(0, 0, 0, 1);
        checks++;
        if (log_dir.size() != 4) begin
            errors++;
            $display("FAIL single_count got %0d expected 4", log_dir.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({log_dir[i], log_body[i], log_tail[i]} !== {6'h05, (i != 0), (i == 3)}) begin
                    errors++;
                    $display("FAIL single_flit%0d got dir=%h b=%b t=%b expected dir=05 b=%b t=%b",
                             i, log_dir[i], log_body[i], log_tail[i], (i != 0), (i == 3));
                end
            end
        end
    endtask

    task automatic test_body_ignores_dir();
        log_clear();
        cyc(1, 1, 6'h02, 1);
        for (int i = 0; i < 3; i++) cyc(1, 1, 6'h1F, 1);
        cyc(0, 0, 0, 1);
        for (int i = 0; i < log_dir.size(); i++) begin
            checks++;
            if (log_dir[i] !== 6'h02) begin
                errors++;
                $display("FAIL body_dir%0d got %h expected 02", i, log_dir[i]);
            end
        end
    endtask

    task automatic test_interleave();
        log_clear();
        for (int i = 0; i < 8; i++) cyc(1, i % 2, (i % 2) ? 6'h03 : 6'h01, 1);
        cyc(0, 0, 0, 1);
        checks++;
        if (log_dir.size() != 8) begin
            errors++;
            $display("FAIL interleave_count got %0d expected 8", log_dir.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if ({log_vc[i], log_dir[i], log_tail[i]} !==
                    {2'(i % 2), (i % 2) ? 6'h03 : 6'h01, (i >= 6)}) begin
                    errors++;
                    $display("FAIL interleave%0d got vc=%0d dir=%h t=%b expected vc=%0d t=%b",
                             i, log_vc[i], log_dir[i], log_tail[i], i % 2, (i >= 6));
                end
            end
        end
    endtask

    task automatic test_invalid_header();
        log_clear();
        cyc(1, 2, 6'h20, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        checks++;
        if (log_dir.size() != 0 || err_cnt != 1) begin
            errors++;
            $display("FAIL invalid_hdr got flits=%0d err_cycles=%0d expected flits=0 err_cycles=1",
                     log_dir.size(), err_cnt);
        end
        log_clear();
        cyc(1, 2, 6'h04, 1);
        for (int i = 0; i < 3; i++) cyc(1, 2, 6'h3F, 1);
        cyc(0, 0, 0, 1);
        checks++;
        if (log_dir.size() < 1 || {log_dir[0], log_body[0]} !== {6'h04, 1'b0}) begin
            errors++;
            $display("FAIL after_invalid got n=%0d dir=%h expected header dir=04",
                     log_dir.size(), (log_dir.size() > 0) ? log_dir[0] : 6'h00);
        end
    endtask

    task automatic test_backpressure();
        log_clear();
        cyc(1, 3, 6'h0A, 1);
        cyc(1, 3, 6'h11, 1);
        valid_i = 1; vc_i = 2'd3; dir_i = 6'h11; ready_i = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({ready_o, valid_o, dir_o, is_body_o, is_tail_o} !== {1'b0, 1'b1, 6'h0A, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL stall%0d got rdy=%b v=%b dir=%h b=%b t=%b expected rdy=0 v=1 dir=0a b=1 t=0",
                         i, ready_o, valid_o, dir_o, is_body_o, is_tail_o);
            end
            @(posedge clk);
            #2;
        end
        cyc(1, 3, 6'h11, 1);
        cyc(1, 3, 6'h11, 1);
        cyc(0, 0, 0, 1);
        checks++;
        if (log_dir.size() != 4) begin
            errors++;
            $display("FAIL bp_count got %0d expected 4", log_dir.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({log_dir[i], log_body[i], log_tail[i]} !== {6'h0A, (i != 0), (i == 3)}) begin
                    errors++;
                    $display("FAIL bp_flit%0d got dir=%h b=%b t=%b", i, log_dir[i], log_body[i], log_tail[i]);
                end
            end
        end
    endtask

    task automatic test_mid_packet_reset();
        cyc(1, 0, 6'h09, 1);
        cyc(1, 0, 6'h09, 1);
        valid_i = 0;
        rst_i   = 1;
        #1;
        checks++;
        if ({valid_o, dir_o, is_body_o, is_tail_o, err_o, vc_busy_o} !== 14'h0) begin
            errors++;
            $display("FAIL async_reset got v=%b dir=%h b=%b t=%b e=%b busy=%b expected all 0",
                     valid_o, dir_o, is_body_o, is_tail_o, err_o, vc_busy_o);
        end
        model_reset();
        @(posedge clk);
        #2;
        rst_i = 0;
        log_clear();
        cyc(1, 0, 6'h0C, 1);
        cyc(0, 0, 0, 1);
        checks++;
        if (log_dir.size() != 1 || {log_dir[0], log_body[0]} !== {6'h0C, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_hdr got n=%0d dir=%h expected header dir=0c",
                     log_dir.size(), (log_dir.size() > 0) ? log_dir[0] : 6'h00);
        end
        for (int i = 0; i < 3; i++) cyc(1, 0, 6'h00, 1);
        cyc(0, 0, 0, 1);
    endtask

    task automatic test_random();
        int d;
        for (int i = 0; i < 400; i++) begin
            d = $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) d = d | 32;
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3), d, $urandom_range(0, 3) != 0);
        end
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
    endtask

    initial begin
        valid_i = 0; vc_i = '0; dir_i = '0; ready_i = 1; rst_i = 1; mon_en = 0;
        err_cnt = 0;
        model_reset();
        test_reset();
        test_single_packet();
        test_body_ignores_dir();
        test_interleave();
        test_invalid_header();
        test_backpressure();
        test_mid_packet_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
